// File: rtl/adder_serial_nbit.sv
// -----------------------------------------------------------------------------
// adder_serial_nbit
//   Digit-serial adder/subtractor. An operation is accepted on start while
//   idle. It then processes DIGIT bits per clock through a ripple stage, with
//   the carry registered between digits. After N = WIDTH/DIGIT cycles the
//   result, carry-out and signed overflow are loaded and done pulses.
//
// Parameters
//   WIDTH  operand/result width (integer multiple of DIGIT)
//   DIGIT  bits processed per clock (1 <= DIGIT <= WIDTH)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  operation request, sampled only while idle
//   a, b   operands (unsigned or two's complement)
//   c_in   carry-in (add) / borrow-in (subtract)
//   sm     0: a + b + c_in, 1: a - b - c_in
//   s      registered result, held until the next completion
//   c_out  carry out of the MSB (subtract: 1 = no borrow)
//   ovf    signed overflow
//   busy   high while an operation is in flight
//   done   one-cycle completion pulse
// -----------------------------------------------------------------------------
module adder_serial_nbit #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sm,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   dsum_full;
   logic [DIGIT-1:0] dsum;
   logic             c_msb_in;
   logic             last;

   // Digit stage plus the merged result for the current cycle.
   // NOTE: every signal assigned here gets a value on every path (defaults
   // first), otherwise synthesis infers a latch.
   always_comb begin
      dsum_full = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry};
      dsum      = dsum_full[DIGIT-1:0];
      // The sum bit is a^b^cin, so XORing the operand bits back out recovers
      // the carry into the digit's MSB. This also works when DIGIT == 1.
      c_msb_in  = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ dsum[DIGIT-1];
      // New digit enters at the top. Written as shifts so that N == 1
      // (DIGIT == WIDTH) needs no zero-width slice.
      r_nxt     = (r_sr >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
      last      = (cnt == CW'(N - 1));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // The shift registers are explicitly cleared so that an aborted operation
   // leaves no stale operand data behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         r_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         s     <= '0;
         c_out <= 1'b0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // Subtract as a + ~b + ~c_in: invert b and the carry seed.
                  a_sr  <= a;
                  b_sr  <= sm ? ~b : b;
                  carry <= c_in ^ sm;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               a_sr  <= a_sr >> DIGIT;
               b_sr  <= b_sr >> DIGIT;
               r_sr  <= r_nxt;
               carry <= dsum_full[DIGIT];
               cnt   <= cnt + CW'(1);
               if (last) begin
                  s     <= r_nxt;
                  c_out <= dsum_full[DIGIT];
                  ovf   <= c_msb_in ^ dsum_full[DIGIT];
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_serial_nbit.sv
// -----------------------------------------------------------------------------
// tb_adder_serial_nbit
//   Bench for adder_serial_nbit. The main instance is WIDTH=16, DIGIT=4.
//   A reference model tracks acceptance and completion timing, and its
//   scoreboard queue holds the expected results. Directed vectors come from a
//   table. Hand-written sequences cover held start, mid-operation reset and a
//   parameter sweep (16/1, 16/16, 8/2).
// -----------------------------------------------------------------------------
module tb_adder_serial_nbit;

   localparam int N = 4;

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        o;
   } res_t;

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sm;
      logic [15:0] s;
      logic        c;
      logic        o;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        c_in = 1'b0, sm = 1'b0;
   logic [15:0] s;
   logic        c_out, ovf, busy, done;

   // Sweep instances share stimulus.
   logic        sw_start = 1'b0;
   logic [15:0] sw_a = '0, sw_b = '0;
   logic        sw_cin = 1'b0, sw_sm = 1'b0;
   logic [15:0] s1, s16;
   logic [7:0]  s8;
   logic        c1, o1, b1, d1, c16, o16, b16, d16, c8, o8, b8, d8;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // Reference timing model and scoreboard.
   res_t sb[$];
   int   m_left = 0;
   logic m_done = 1'b0;
   logic hs_phase = 1'b0;
   int   prev_done = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   adder_serial_nbit #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
      .sm(sm), .s(s), .c_out(c_out), .ovf(ovf), .busy(busy), .done(done));

   adder_serial_nbit #(.WIDTH(16), .DIGIT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(sw_start), .a(sw_a), .b(sw_b),
      .c_in(sw_cin), .sm(sw_sm), .s(s1), .c_out(c1), .ovf(o1), .busy(b1),
      .done(d1));

   adder_serial_nbit #(.WIDTH(16), .DIGIT(16)) u16 (
      .clk(clk), .rst_n(rst_n), .start(sw_start), .a(sw_a), .b(sw_b),
      .c_in(sw_cin), .sm(sw_sm), .s(s16), .c_out(c16), .ovf(o16), .busy(b16),
      .done(d16));

   adder_serial_nbit #(.WIDTH(8), .DIGIT(2)) u8 (
      .clk(clk), .rst_n(rst_n), .start(sw_start), .a(sw_a[7:0]),
      .b(sw_b[7:0]), .c_in(sw_cin), .sm(sw_sm), .s(s8), .c_out(c8), .ovf(o8),
      .busy(b8), .done(d8));

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference, w bits wide (w <= 16).
   function automatic res_t ref_op(input logic [15:0] fa, input logic [15:0] fb,
                                   input logic fcin, input logic fsm, input int w);
      logic [16:0] mask;
      logic [16:0] bb;
      logic [16:0] full;
      res_t        r;
      mask = (17'd1 << w) - 17'd1;
      bb   = {1'b0, (fsm ? ~fb : fb)} & mask;
      full = ({1'b0, fa} & mask) + bb + {16'd0, fcin ^ fsm};
      r.s  = full[15:0] & mask[15:0];
      r.c  = full[w];
      r.o  = (fa[w-1] == bb[w-1]) && (r.s[w-1] != fa[w-1]);
      return r;
   endfunction

   // Model: accept when idle, complete N edges later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_done = 1'b0;
         sb.delete();
      end else begin
         m_done = 1'b0;
         if (m_left == 0) begin
            if (start) begin
               sb.push_back(ref_op(a, b, c_in, sm, 16));
               m_left = N;
            end
         end else begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
         end
      end
   end

   // Monitor: handshake timing and scoreboard compare on each done.
   always @(negedge clk) begin
      if (rst_n) begin
         check("busy", busy, m_left != 0);
         check("done", done, m_done);
         if (done) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               res_t e;
               e = sb.pop_front();
               check("sb_s", s, e.s);
               check("sb_c_out", c_out, e.c);
               check("sb_ovf", ovf, e.o);
            end
            if (hs_phase) begin
               if (prev_done >= 0) check("done_gap", cyc - prev_done, N + 1);
               prev_done = cyc;
            end
         end
      end
   end

   // Pulse start with the given operands, scramble the inputs after capture,
   // and wait (bounded) for done while checking that s holds.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tcin, input logic tsm);
      logic [15:0] s_hold;
      int          t;
      s_hold = s;
      a = ta; b = tb_; c_in = tcin; sm = tsm; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      c_in = 1'($urandom); sm = 1'($urandom);
      t = 0;
      while (t < 20) begin
         @(negedge clk);
         t++;
         if (done) break;
         check("s_hold", s, s_hold);
      end
      if (!done) check("done_timeout", 0, 1);
      else       check("latency", t, N);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{"add",       16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{"wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{"add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{"sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{"sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{"sub_borrow",16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_s", s, 16'h0);
      check("rst_c_out", c_out, 0);
      check("rst_ovf", ovf, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table.
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sm);
         check({vecs[i].name, "_s"}, s, vecs[i].s);
         check({vecs[i].name, "_c_out"}, c_out, vecs[i].c);
         check({vecs[i].name, "_ovf"}, ovf, vecs[i].o);
         @(negedge clk);
         check({vecs[i].name, "_done_clear"}, done, 0);
      end

      // Start held high with operands changing every cycle.
      hs_phase  = 1'b1;
      prev_done = -1;
      start     = 1'b1;
      for (int i = 0; i < 32; i++) begin
         a = 16'($urandom); b = 16'($urandom);
         c_in = 1'($urandom); sm = 1'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      repeat (N + 2) @(negedge clk);
      hs_phase = 1'b0;

      // Reset two cycles into an operation.
      a = 16'h00FF; b = 16'h0F0F; c_in = 1'b0; sm = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_s", s, 16'h0);
      check("midrst_c_out", c_out, 0);
      check("midrst_ovf", ovf, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("post_rst_no_done", done, 0);
      end
      run_op(16'hA5A5, 16'h1111, 1'b1, 1'b0);
      check("post_rst_s", s, 16'hB6B7);
      check("post_rst_c_out", c_out, 0);
      check("post_rst_ovf", ovf, 0);

      // Parameter sweep.
      for (int k = 0; k < 8; k++) begin
         res_t e16, e8;
         logic seen1, seen16, seen8;
         sw_a = 16'($urandom); sw_b = 16'($urandom);
         sw_cin = 1'($urandom); sw_sm = 1'($urandom);
         if (k == 0) begin sw_a = 16'h0003; sw_b = 16'h0005; sw_cin = 1'b0; sw_sm = 1'b1; end
         e16 = ref_op(sw_a, sw_b, sw_cin, sw_sm, 16);
         e8  = ref_op({8'h0, sw_a[7:0]}, {8'h0, sw_b[7:0]}, sw_cin, sw_sm, 8);
         seen1 = 1'b0; seen16 = 1'b0; seen8 = 1'b0;
         sw_start = 1'b1;
         @(negedge clk);
         sw_start = 1'b0;
         for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (d1 && !seen1) begin
               seen1 = 1'b1;
               check("d1_latency", t, 16);
               check("d1_s", s1, e16.s);
               check("d1_c_out", c1, e16.c);
               check("d1_ovf", o1, e16.o);
            end
            if (d16 && !seen16) begin
               seen16 = 1'b1;
               check("d16_latency", t, 1);
               check("d16_s", s16, e16.s);
               check("d16_c_out", c16, e16.c);
               check("d16_ovf", o16, e16.o);
            end
            if (d8 && !seen8) begin
               seen8 = 1'b1;
               check("w8_latency", t, 4);
               check("w8_s", s8, e8.s[7:0]);
               check("w8_c_out", c8, e8.c);
               check("w8_ovf", o8, e8.o);
            end
         end
         if (!seen1)  check("d1_timeout", 0, 1);
         if (!seen16) check("d16_timeout", 0, 1);
         if (!seen8)  check("w8_timeout", 0, 1);
      end

      repeat (2) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
